// File: rtl/tlul_host_adapter.sv
// tlul_host_adapter: bridges a req/gnt/rvalid host port onto a TL-UL master
// port. Each granted request takes a source ID from a ring of NOUT slots.
// Responses may return out of order, but they are handed back in issue order.
// Optional response checking is enabled by TLUL_HOST_ADAPTER_RSP_CHECK_EN.
module tlul_host_adapter #(
  parameter int TL_AW  = 32,
  parameter int TL_DW  = 32,
  parameter int TL_AIW = 8,
  parameter int TL_DIW = 1,
  parameter int TL_DBW = TL_DW >> 3,
  parameter int TL_SZW = $clog2($clog2(TL_DBW) + 1),
  parameter int NOUT   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  output logic              gnt,
  input  logic              we,
  input  logic [TL_AW-1:0]  addr,
  input  logic [TL_DW-1:0]  wdata,
  input  logic [TL_DBW-1:0] be,
  output logic              rvalid,
  output logic [TL_DW-1:0]  rdata,
  output logic              err,
  output logic              proto_err,
  output logic              a_valid,
  output logic [2:0]        a_opcode,
  output logic [2:0]        a_param,
  output logic [TL_SZW-1:0] a_size,
  output logic [TL_AIW-1:0] a_source,
  output logic [TL_AW-1:0]  a_address,
  output logic [TL_DBW-1:0] a_mask,
  output logic [TL_DW-1:0]  a_data,
  input  logic              a_ready,
  input  logic              d_valid,
  input  logic [2:0]        d_opcode,
  input  logic [2:0]        d_param,
  input  logic [TL_SZW-1:0] d_size,
  input  logic [TL_AIW-1:0] d_source,
  input  logic [TL_DIW-1:0] d_sink,
  input  logic [TL_DW-1:0]  d_data,
  input  logic              d_error,
  output logic              d_ready
);

  localparam int PW  = $clog2(NOUT);
  localparam int CW  = $clog2(NOUT + 1);
  localparam int OFS = $clog2(TL_DBW);

  typedef enum logic [1:0] {IDLE, ISSUED, DONE} slot_state_e;

  slot_state_e       slot_state     [NOUT];
  slot_state_e       slot_state_nxt [NOUT];
  logic              slot_we        [NOUT];
  logic [TL_DW-1:0]  slot_rdata     [NOUT];
  logic              slot_err       [NOUT];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic [PW-1:0] d_idx;
  logic          d_hit;
  logic          retire;
  logic          rsp_bad;

  // Every issued request already owns a slot, so D beats are never stalled.
  assign d_ready = 1'b1;

  assign gnt    = req && (count < CW'(NOUT)) && (!a_valid || a_ready);
  assign d_idx  = d_source[PW-1:0];
  assign d_hit  = d_valid && (32'(d_source) < 32'(NOUT)) && (slot_state[d_idx] == ISSUED);
  assign retire = (slot_state[rptr] == DONE);

  assign rvalid = retire;
  assign rdata  = retire ? slot_rdata[rptr] : '0;
  assign err    = retire && slot_err[rptr];

`ifdef TLUL_HOST_ADAPTER_RSP_CHECK_EN
  logic [1:0] unused_d;
  assign unused_d = {^d_param, ^d_sink};

  // A beat is malformed when its opcode does not match the request kind or its size is not a full word.
  always_comb begin
    rsp_bad = 1'b0;
    if (slot_we[d_idx] ? (d_opcode != 3'd0) : (d_opcode != 3'd1)) rsp_bad = 1'b1;
    if (d_size != TL_SZW'(OFS)) rsp_bad = 1'b1;
  end

  // Sticky flag for any stray or malformed D beat; only reset clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      proto_err <= 1'b0;
    end else if (d_valid && (!d_hit || rsp_bad)) begin
      proto_err <= 1'b1;
    end
  end
`else
  logic [3:0] unused_d;
  assign unused_d  = {^d_param, ^d_sink, ^d_opcode, ^d_size};
  assign rsp_bad   = 1'b0;
  assign proto_err = 1'b0;
`endif

  // Slot lifecycle: grant claims the write slot, a matching D beat completes it, retire frees it.
  always_comb begin
    for (int i = 0; i < NOUT; i++) slot_state_nxt[i] = slot_state[i];
    if (gnt)    slot_state_nxt[wptr]  = ISSUED;
    if (d_hit)  slot_state_nxt[d_idx] = DONE;
    if (retire) slot_state_nxt[rptr]  = IDLE;
  end

  // Slot state and per-slot response storage; writes always return zero data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NOUT; i++) begin
        slot_state[i] <= IDLE;
        slot_we[i]    <= 1'b0;
        slot_rdata[i] <= '0;
        slot_err[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NOUT; i++) slot_state[i] <= slot_state_nxt[i];
      if (gnt) slot_we[wptr] <= we;
      if (d_hit) begin
        slot_rdata[d_idx] <= slot_we[d_idx] ? '0 : d_data;
        slot_err[d_idx]   <= d_error || rsp_bad;
      end
    end
  end

  // Issue and retire pointers wrap naturally because NOUT is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (gnt)    wptr <= wptr + PW'(1);
      if (retire) rptr <= rptr + PW'(1);
      case ({gnt, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A-channel holding register: loads on grant, holds until the crossbar accepts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_valid   <= 1'b0;
      a_opcode  <= 3'd0;
      a_param   <= 3'd0;
      a_size    <= '0;
      a_source  <= '0;
      a_address <= '0;
      a_mask    <= '0;
      a_data    <= '0;
    end else if (gnt) begin
      a_valid   <= 1'b1;
      a_param   <= 3'd0;
      a_size    <= TL_SZW'(OFS);
      a_source  <= TL_AIW'(wptr);
      a_address <= addr & ~TL_AW'(TL_DBW - 1);
      if (!we) begin
        a_opcode <= 3'd4;
        a_mask   <= '1;
        a_data   <= '0;
      end else if (&be) begin
        a_opcode <= 3'd0;
        a_mask   <= be;
        a_data   <= wdata;
      end else begin
        a_opcode <= 3'd1;
        a_mask   <= be;
        a_data   <= wdata;
      end
    end else if (a_ready) begin
      a_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter with a small behavioural TL-UL slave.
// Expected results are hand-computed; proto_err expectations follow
// TLUL_HOST_ADAPTER_RSP_CHECK_EN.
module tb_tlul_host_adapter;

`ifdef TLUL_HOST_ADAPTER_RSP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        req;
  logic        gnt;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        proto_err;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_ready;
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic [0:0]  d_sink;
  logic [31:0] d_data;
  logic        d_error;
  logic        d_ready;

  typedef struct packed {
    logic [7:0]  src;
    logic [2:0]  op;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  msk;
  } beat_t;

  beat_t       pend [$];
  beat_t       mon;
  logic [31:0] mem [logic [31:0]];
  int          test_count = 0;
  int          fail_count = 0;
  int          rsp_count  = 0;

  tlul_host_adapter dut (
    .clk(clk), .rstn(rstn), .req(req), .gnt(gnt), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .rvalid(rvalid), .rdata(rdata), .err(err),
    .proto_err(proto_err), .a_valid(a_valid), .a_opcode(a_opcode),
    .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .a_ready(a_ready), .d_valid(d_valid), .d_opcode(d_opcode),
    .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_data(d_data), .d_error(d_error), .d_ready(d_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted A beats and count response pulses mid-cycle.
  always @(negedge clk) begin
    if (rstn && a_valid && a_ready) begin
      mon.src = a_source;
      mon.op  = a_opcode;
      mon.adr = a_address;
      mon.dat = a_data;
      mon.msk = a_mask;
      pend.push_back(mon);
    end
    if (rvalid) rsp_count++;
  end

  // Hard time limit so a stuck design still terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] ad,
                               input logic [31:0] wd, input logic [3:0] b);
    req   = r;
    we    = w;
    addr  = ad;
    wdata = wd;
    be    = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Slave answer for recorded beat qi: 0x8000 and above is an unmapped error region.
  task automatic sendD(input int qi);
    beat_t       p;
    logic        bad;
    logic [31:0] cur;
    p   = pend[qi];
    bad = (p.adr >= 32'h8000);
    cur = mem.exists(p.adr) ? mem[p.adr] : 32'h0;
    d_valid  = 1'b1;
    d_source = p.src;
    d_size   = 2'd2;
    d_param  = 3'd0;
    d_sink   = 1'b0;
    d_error  = bad;
    if (p.op == 3'd4) begin
      d_opcode = 3'd1;
      d_data   = bad ? 32'h0 : cur;
    end else begin
      d_opcode = 3'd0;
      d_data   = 32'h0;
      if (!bad) begin
        for (int b = 0; b < 4; b++) if (p.msk[b]) cur[8*b +: 8] = p.dat[8*b +: 8];
        mem[p.adr] = cur;
      end
    end
    tick();
    d_valid = 1'b0;
  endtask

  task automatic sendRaw(input logic [7:0] src, input logic [2:0] op, input logic [1:0] sz,
                         input logic [31:0] dat, input logic derr);
    d_valid  = 1'b1;
    d_source = src;
    d_opcode = op;
    d_size   = sz;
    d_param  = 3'd0;
    d_sink   = 1'b0;
    d_data   = dat;
    d_error  = derr;
    tick();
    d_valid = 1'b0;
  endtask

  initial begin
    mem[32'h4000] = 32'hAABBCCDD;
    mem[32'h0020] = 32'h11111111;
    mem[32'h4010] = 32'h22222222;
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    a_ready = 1'b1;
    d_valid = 1'b0; d_opcode = 3'd0; d_param = 3'd0; d_size = 2'd0;
    d_source = 8'd0; d_sink = 1'b0; d_data = 32'h0; d_error = 1'b0;
    repeat (2) tick();
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_a_valid", a_valid, 0);
    checkOutput("rst_d_ready", d_ready, 1);
    checkOutput("rst_proto_err", proto_err, 0);
    rstn = 1'b1;
    tick();

    // Full write then read of 0x10, zero-wait slave.
    applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    #1 checkOutput("t1_gnt_wr", gnt, 1);
    tick();
    checkOutput("t1_op_wr", a_opcode, 0);
    checkOutput("t1_src_wr", a_source, 0);
    checkOutput("t1_addr_wr", a_address, 32'h10);
    checkOutput("t1_size", a_size, 2);
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, 4'h0);
    #1 checkOutput("t1_gnt_rd", gnt, 1);
    tick();
    checkOutput("t1_op_rd", a_opcode, 4);
    checkOutput("t1_src_rd", a_source, 1);
    checkOutput("t1_addr_rd", a_address, 32'h10);
    checkOutput("t1_mask_rd", a_mask, 4'hF);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sendD(0);
    checkOutput("t1_rvalid_wr", rvalid, 1);
    checkOutput("t1_rdata_wr", rdata, 0);
    sendD(1);
    checkOutput("t1_rvalid_rd", rvalid, 1);
    checkOutput("t1_rdata_rd", rdata, 32'hDEADBEEF);
    checkOutput("t1_err_rd", err, 0);
    tick();
    checkOutput("t1_rvalid_end", rvalid, 0);

    // Partial write of the low half-word at 0x4000, then read back.
    applyStimulus(1'b1, 1'b1, 32'h4000, 32'h1234, 4'h3);
    tick();
    checkOutput("t2_op", a_opcode, 1);
    checkOutput("t2_mask", a_mask, 4'h3);
    checkOutput("t2_data", a_data, 32'h1234);
    applyStimulus(1'b1, 1'b0, 32'h4000, 32'h0, 4'h0);
    tick();
    checkOutput("t2_src_rd", a_source, 3);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sendD(2);
    checkOutput("t2_rvalid_wr", rvalid, 1);
    sendD(3);
    checkOutput("t2_rdata_rd", rdata, 32'hAABB1234);
    tick();

    // Three reads, answered in reverse order; the 0x8000 one errors.
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    checkOutput("t3_src_wrap", a_source, 0);
    applyStimulus(1'b1, 1'b0, 32'h8000, 32'h0, 4'h0);
    tick();
    checkOutput("t3_src1", a_source, 1);
    applyStimulus(1'b1, 1'b0, 32'h4010, 32'h0, 4'h0);
    tick();
    checkOutput("t3_src2", a_source, 2);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    sendD(6);
    checkOutput("t3_hold_a", rvalid, 0);
    sendD(5);
    checkOutput("t3_hold_b", rvalid, 0);
    sendD(4);
    checkOutput("t3_r0_data", rdata, 32'h11111111);
    checkOutput("t3_r0_err", err, 0);
    tick();
    checkOutput("t3_r1_valid", rvalid, 1);
    checkOutput("t3_r1_err", err, 1);
    tick();
    checkOutput("t3_r2_data", rdata, 32'h22222222);
    tick();
    checkOutput("t3_end", rvalid, 0);

    // Fill all four slots with no responses; the fifth request waits for a retire.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1 checkOutput("t4_gnt1", gnt, 1);
    tick();
    checkOutput("t4_src3", a_source, 3);
    tick();
    checkOutput("t4_src0_wrap", a_source, 0);
    tick();
    checkOutput("t4_gnt4", gnt, 1);
    tick();
    checkOutput("t4_full_gnt", gnt, 0);
    tick();
    checkOutput("t4_full_gnt2", gnt, 0);
    sendD(7);
    checkOutput("t4_retire_rvalid", rvalid, 1);
    checkOutput("t4_retire_gnt", gnt, 0);
    tick();
    checkOutput("t4_after_gnt", gnt, 1);
    tick();
    checkOutput("t4_src5", a_source, 3);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sendD(8);
    sendD(9);
    sendD(10);
    tick();
    sendD(11);
    tick();

    // A-channel stall: payload must hold, then back-to-back beats.
    a_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h50, 32'hCAFEF00D, 4'hF);
    #1 checkOutput("t5_gnt0", gnt, 1);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h54, 32'h0BADCAFE, 4'hF);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("t5_stall_valid", a_valid, 1);
      checkOutput("t5_stall_data", a_data, 32'hCAFEF00D);
      checkOutput("t5_stall_addr", a_address, 32'h50);
      checkOutput("t5_stall_gnt", gnt, 0);
      if (c < 2) tick();
    end
    a_ready = 1'b1;
    #1 checkOutput("t5_release_gnt", gnt, 1);
    tick();
    checkOutput("t5_b2b_valid", a_valid, 1);
    checkOutput("t5_b2b_data", a_data, 32'h0BADCAFE);
    checkOutput("t5_b2b_src", a_source, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t5_idle_valid", a_valid, 0);
    sendD(12);
    sendD(13);
    tick();

    // Stray source 7 and a wrong-opcode response.
    sendRaw(8'd7, 3'd1, 2'd2, 32'hAAAA, 1'b0);
    checkOutput("t6_stray_rvalid", rvalid, 0);
    checkOutput("t6_stray_proto", proto_err, CHK);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    checkOutput("t6_src", a_source, 2);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    sendRaw(8'd2, 3'd0, 2'd2, 32'h5555, 1'b0);
    checkOutput("t6_badop_rvalid", rvalid, 1);
    checkOutput("t6_badop_rdata", rdata, 32'h5555);
    checkOutput("t6_badop_err", err, CHK);
    tick();

    // Reset in the middle of a burst, then a stale D beat.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rstn = 1'b0;
    #1;
    checkOutput("t7_rst_a_valid", a_valid, 0);
    checkOutput("t7_rst_a_source", a_source, 0);
    checkOutput("t7_rst_a_opcode", a_opcode, 0);
    checkOutput("t7_rst_gnt", gnt, 0);
    checkOutput("t7_rst_rvalid", rvalid, 0);
    checkOutput("t7_rst_proto", proto_err, 0);
    tick();
    rstn = 1'b1;
    tick();
    sendRaw(8'd3, 3'd1, 2'd2, 32'h9999, 1'b0);
    checkOutput("t7_stale_rvalid", rvalid, 0);
    checkOutput("t7_stale_proto", proto_err, CHK);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    checkOutput("t7_src_after_rst", a_source, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();

    checkOutput("total_rvalids", rsp_count, 15);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
